mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Non-memory instructions pass straight through to the writeback fields.
- Loads and stores go out on a req/ack data bus through a small FSM. The FSM raises a stall request while the access is outstanding and aborts on timeout.
- Handles byte/half/word lane selection, load sign/zero extension, store data replication and misalignment detection.

Parameters:
- TIMEOUT_CYCLES, 16, maximum WAIT cycles without dbus_ack before abort; legal range 2..255.

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high (rst==`RST_ENABLE, 1'b1)
- mem_waddr_i  in  5  destination register from EX/MEM
- mem_we_i  in  1  register write enable from EX/MEM
- mem_wdata_i  in  32  ALU result from EX/MEM
- mem_op_i  in  4  memory op: 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9..15 treated as NONE
- mem_addr_i  in  32  effective address
- mem_sdata_i  in  32  store source register value
- wb_waddr_o  out  5  to MEM/WB
- wb_we_o  out  1  to MEM/WB
- wb_wdata_o  out  32  to MEM/WB
- dbus_req_o  out  1  bus request
- dbus_we_o  out  1  1 = store
- dbus_addr_o  out  32  word address: {mem_addr_i[31:2],2'b00}
- dbus_sel_o  out  4  byte lane enables
- dbus_wdata_o  out  32  store data, lane-replicated
- dbus_ack_i  in  1  one-cycle completion pulse
- dbus_rdata_i  in  32  read data, valid with ack
- stall_req_o  out  1  hold EX/MEM and upstream stages
- misalign_o  out  1  misaligned access flag, combinational
- bus_err_o  out  1  timeout flag, asserted in the DONE cycle after an abort

Behaviour:
- FSM states: IDLE, WAIT, DONE. Wait counter is 8 bits. Read buffer rbuf is 32 bits.
- Reset (rst=1 at edge): state=IDLE, counter=0, rbuf=0.
- While rst=1, every output is forced to 0.
- IDLE, op NONE:
  - wb_* = mem_*_i.
  - stall_req=0, dbus_req=0.
- Misalignment check, any state:
  - LH/LHU/SH with addr[0]=1 → misaligned.
  - LW/SW with addr[1:0]!=0 → misaligned.
  - Misaligned → misalign_o=1, wb_we=0, no bus access, no stall, state stays IDLE.
- IDLE, aligned load/store:
  - stall_req=1, dbus_req=0.
  - Next state WAIT, counter cleared.
- WAIT:
  - dbus_req=1, stall_req=1.
  - dbus_we=1 for SB/SH/SW.
  - Counter increments each cycle without ack.
- WAIT, dbus_ack=1: capture dbus_rdata into rbuf, go to DONE.
- WAIT, no ack and counter==TIMEOUT_CYCLES-1: go to DONE with the error flag set.
- WAIT, ack in the same cycle as the timeout: ack wins, no error.
- DONE:
  - stall_req=0, dbus_req=0. Next state IDLE unconditionally.
  - Load: wb_we=mem_we_i, wb_wdata = extended data from rbuf.
  - Store: wb_* = mem_*_i.
  - Error: wb_we=0 and bus_err_o=1.
  - EX/MEM advances on this same edge.
- dbus_ack in IDLE or DONE is ignored.
- Latency: ack in the k-th WAIT cycle → stall_req high for k+1 cycles; result presented on the following cycle.
- Lanes (little-endian):
  - Byte: sel = 1<<addr[1:0].
  - Half: sel = 0011 when addr[1]=0, 1100 when addr[1]=1.
  - Word: sel = 1111.
- Store data:
  - SB: {4{sdata[7:0]}}.
  - SH: {2{sdata[15:0]}}.
  - SW: sdata.
- Load extension:
  - LB/LH: sign-extend the selected lane.
  - LBU/LHU: zero-extend the selected lane.
  - LW: rbuf unchanged.
- Inputs are stable from IDLE through DONE because the stall holds EX/MEM. The bus address and sel are driven from the inputs.
- Reset mid-WAIT: dbus_req drops on the next cycle; any later ack is ignored.

Decomposition:
- Shared DEFINE.v additions:
  - mem_op codes (`MEM_OP_*`).
  - FSM state codes (`MS_IDLE/WAIT/DONE`).
  - `SEL_*` constants.
  - Existing `RST_ENABLE, `ZERO_WORD, `NOP_REG_ADDR reused.
- Sub-module: mem_lane_align, combinational.
  - Inputs: op, addr[1:0], sdata, rdata.
  - Outputs: sel, replicated store data, extended load data.

Test Plan:
- Op NONE, waddr=3, we=1, wdata=0x1234 → wb_* identical the same cycle; stall_req=0; dbus_req=0.
- LB at addr 0x103, ack in first WAIT cycle with rdata=0x80FF_FF00 → sel=1000; stall for 2 cycles; wb_wdata=0xFFFF_FF80.
- SH at 0x202, sdata=0xDEAD_BEEF, ack after 3 WAIT cycles → dbus_we=1, sel=1100, wdata=0xBEEF_BEEF; stall for 4 cycles; wb_we=0.
- LW at 0x101 → misalign_o=1, wb_we=0, no dbus_req, no stall.
- LW, ack never arrives, TIMEOUT_CYCLES=4 → 4 WAIT cycles, then DONE with bus_err_o=1 and wb_we=0; ack in the same cycle as the 4th WAIT cycle → normal completion instead.
- rst pulsed during WAIT → next cycle IDLE, all outputs 0; subsequent stray ack has no effect.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: op codes, FSM states,
// byte-lane select constants and op classification helpers.
package mem_stage_pkg;

  typedef enum logic [3:0] {
    MEM_OP_NONE = 4'd0,
    MEM_OP_LB   = 4'd1,
    MEM_OP_LBU  = 4'd2,
    MEM_OP_LH   = 4'd3,
    MEM_OP_LHU  = 4'd4,
    MEM_OP_LW   = 4'd5,
    MEM_OP_SB   = 4'd6,
    MEM_OP_SH   = 4'd7,
    MEM_OP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_WAIT = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;

  localparam logic [3:0]  SEL_NONE     = 4'b0000;
  localparam logic [3:0]  SEL_BYTE0    = 4'b0001;
  localparam logic [3:0]  SEL_HALF_LO  = 4'b0011;
  localparam logic [3:0]  SEL_HALF_HI  = 4'b1100;
  localparam logic [3:0]  SEL_WORD     = 4'b1111;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic [4:0]  NOP_REG_ADDR = 5'd0;

  function automatic logic op_is_load(input logic [3:0] op);
    return op inside {MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW};
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return op inside {MEM_OP_SB, MEM_OP_SH, MEM_OP_SW};
  endfunction

  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] a);
    case (op)
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return a[0];
      MEM_OP_LW, MEM_OP_SW:             return a != 2'b00;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lane_align.sv
// Little-endian lane steering: byte enables, store-data replication and
// load-data extraction with sign/zero extension.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] sdata_rep,
  output logic [31:0] ldata
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{addr, 3'b000} +: 8];
    half_lane = addr[1] ? rdata[31:16] : rdata[15:0];

    case (op)
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: sel = SEL_BYTE0 << addr;
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: sel = addr[1] ? SEL_HALF_HI : SEL_HALF_LO;
      MEM_OP_LW, MEM_OP_SW:             sel = SEL_WORD;
      default:                          sel = SEL_NONE;
    endcase

    // Replicate so the correct lane carries the data whatever the offset.
    case (op)
      MEM_OP_SB: sdata_rep = {4{sdata[7:0]}};
      MEM_OP_SH: sdata_rep = {2{sdata[15:0]}};
      default:   sdata_rep = sdata;
    endcase

    case (op)
      MEM_OP_LB:  ldata = {{24{byte_lane[7]}}, byte_lane};
      MEM_OP_LBU: ldata = {24'h0, byte_lane};
      MEM_OP_LH:  ldata = {{16{half_lane[15]}}, half_lane};
      MEM_OP_LHU: ldata = {16'h0, half_lane};
      default:    ldata = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: passes ALU results through, runs loads/stores over a
// req/ack bus with an IDLE/WAIT/DONE FSM, stall request and timeout abort.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_waddr_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_sdata_i,
  output logic [4:0]  wb_waddr_o,
  output logic        wb_we_o,
  output logic [31:0] wb_wdata_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_sel_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        stall_req_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  ms_state_e   state;
  logic [7:0]  cnt;
  logic [31:0] rbuf;
  logic        err;
  logic        load, store, misalign, start;
  logic [3:0]  sel;
  logic [31:0] sdata_rep, ldata;

  assign load     = op_is_load(mem_op_i);
  assign store    = op_is_store(mem_op_i);
  assign misalign = op_misaligned(mem_op_i, mem_addr_i[1:0]);
  assign start    = (load || store) && !misalign;

  mem_lane_align u_align (
    .op        (mem_op_i),
    .addr      (mem_addr_i[1:0]),
    .sdata     (mem_sdata_i),
    .rdata     (rbuf),
    .sel       (sel),
    .sdata_rep (sdata_rep),
    .ldata     (ldata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MS_IDLE;
      cnt   <= 8'd0;
      rbuf  <= ZERO_WORD;
      err   <= 1'b0;
    end else begin
      case (state)
        MS_IDLE: if (start) begin
          state <= MS_WAIT;
          cnt   <= 8'd0;
          err   <= 1'b0;
        end
        // An ack arriving on the timeout cycle still completes normally.
        MS_WAIT: if (dbus_ack_i) begin
          rbuf  <= dbus_rdata_i;
          state <= MS_DONE;
        end else if (cnt == CNT_LAST) begin
          err   <= 1'b1;
          state <= MS_DONE;
        end else begin
          cnt <= cnt + 8'd1;
        end
        MS_DONE: state <= MS_IDLE;
        default: state <= MS_IDLE;
      endcase
    end
  end

  always_comb begin
    wb_waddr_o   = mem_waddr_i;
    wb_we_o      = mem_we_i;
    wb_wdata_o   = mem_wdata_i;
    dbus_req_o   = 1'b0;
    dbus_we_o    = 1'b0;
    dbus_addr_o  = {mem_addr_i[31:2], 2'b00};
    dbus_sel_o   = sel;
    dbus_wdata_o = sdata_rep;
    stall_req_o  = 1'b0;
    misalign_o   = misalign;
    bus_err_o    = 1'b0;

    case (state)
      MS_IDLE: if (start) begin
        stall_req_o = 1'b1;
        wb_we_o     = 1'b0;
      end
      MS_WAIT: begin
        dbus_req_o  = 1'b1;
        dbus_we_o   = store;
        stall_req_o = 1'b1;
        wb_we_o     = 1'b0;
      end
      MS_DONE: if (err) begin
        wb_we_o   = 1'b0;
        bus_err_o = 1'b1;
      end else if (load) begin
        wb_wdata_o = ldata;
      end
      default: ;
    endcase

    if (misalign) wb_we_o = 1'b0;

    if (rst) begin
      wb_waddr_o   = NOP_REG_ADDR;
      wb_we_o      = 1'b0;
      wb_wdata_o   = ZERO_WORD;
      dbus_req_o   = 1'b0;
      dbus_we_o    = 1'b0;
      dbus_addr_o  = ZERO_WORD;
      dbus_sel_o   = SEL_NONE;
      dbus_wdata_o = ZERO_WORD;
      stall_req_o  = 1'b0;
      misalign_o   = 1'b0;
      bus_err_o    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, randomized transactions against
// a transaction-level reference model, and reset corner sequences.
module tb_mem_stage;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_waddr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_sdata;
  logic [4:0]  wb_waddr;
  logic        wb_we;
  logic [31:0] wb_wdata;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        stall_req, misalign, bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_waddr_i  (mem_waddr),
    .mem_we_i     (mem_we),
    .mem_wdata_i  (mem_wdata),
    .mem_op_i     (mem_op),
    .mem_addr_i   (mem_addr),
    .mem_sdata_i  (mem_sdata),
    .wb_waddr_o   (wb_waddr),
    .wb_we_o      (wb_we),
    .wb_wdata_o   (wb_wdata),
    .dbus_req_o   (dbus_req),
    .dbus_we_o    (dbus_we),
    .dbus_addr_o  (dbus_addr),
    .dbus_sel_o   (dbus_sel),
    .dbus_wdata_o (dbus_wdata),
    .dbus_ack_i   (dbus_ack),
    .dbus_rdata_i (dbus_rdata),
    .stall_req_o  (stall_req),
    .misalign_o   (misalign),
    .bus_err_o    (bus_err)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [4:0]  waddr;
    logic        we;
    logic [31:0] wdata;
    int          ack_at;     // WAIT cycle carrying ack; > T means none in time
    logic        exp_mis;
    logic [3:0]  exp_sel;
    logic [31:0] exp_dwd;
    int          exp_stall;  // cycles with stall_req high
    logic        exp_wbwe;
    logic [31:0] exp_wbd;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level reference: size/offset arithmetic, not lane muxes.
  function automatic vec_t model(input logic [3:0] op, input logic [31:0] addr,
                                 input logic [31:0] sdata, input logic [31:0] rdata,
                                 input logic [4:0] waddr, input logic we,
                                 input logic [31:0] wdata, input int ack_at);
    vec_t v;
    int size, off, base;
    bit ld, sg, er;
    logic [31:0] mask, val, dwd;
    v = '{op, addr, sdata, rdata, waddr, we, wdata, ack_at,
          1'b0, 4'h0, 32'h0, 0, we, wdata, 1'b0};
    size = 0; ld = 0; sg = 0;
    case (op)
      4'd1: begin size = 1; ld = 1; sg = 1; end
      4'd2: begin size = 1; ld = 1; end
      4'd3: begin size = 2; ld = 1; sg = 1; end
      4'd4: begin size = 2; ld = 1; end
      4'd5: begin size = 4; ld = 1; end
      4'd6: size = 1;
      4'd7: size = 2;
      4'd8: size = 4;
      default: size = 0;
    endcase
    if (size == 0) return v;
    off  = int'(addr % 4);
    base = off - (off % size);
    if (off % size != 0) begin
      v.exp_mis  = 1'b1;
      v.exp_wbwe = 1'b0;
      return v;
    end
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
    v.exp_sel = 4'(((1 << size) - 1) << base);
    dwd = 32'h0;
    for (int k = 0; k < 4; k += size) dwd |= (sdata & mask) << (8 * k);
    v.exp_dwd = dwd;
    val = (rdata >> (8 * base)) & mask;
    if (sg && val[8 * size - 1]) val |= ~mask;
    er = ack_at > T;
    v.exp_err   = er;
    v.exp_stall = (er ? T : ack_at) + 1;
    v.exp_wbwe  = er ? 1'b0 : we;
    v.exp_wbd   = (ld && !er) ? val : wdata;
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int  nstall;
    bit  done;
    bit  st;
    st = (v.op == 4'd6) || (v.op == 4'd7) || (v.op == 4'd8);
    mem_op = v.op; mem_addr = v.addr; mem_sdata = v.sdata;
    mem_waddr = v.waddr; mem_we = v.we; mem_wdata = v.wdata;
    dbus_ack = 1'b0; dbus_rdata = v.rdata;
    #1;
    chk({tag, ".misalign"}, misalign, v.exp_mis);
    if (v.exp_stall == 0) begin
      chk({tag, ".stall"}, stall_req, 1'b0);
      chk({tag, ".req"}, dbus_req, 1'b0);
      chk({tag, ".wb_we"}, wb_we, v.exp_wbwe);
      chk({tag, ".wb_waddr"}, wb_waddr, v.waddr);
      chk({tag, ".wb_wdata"}, wb_wdata, v.exp_wbd);
      @(posedge clk); #1;
      return;
    end
    chk({tag, ".idle_stall"}, stall_req, 1'b1);
    chk({tag, ".idle_req"}, dbus_req, 1'b0);
    nstall = 1;
    done = 0;
    for (int w = 1; w <= v.exp_stall + 4 && !done; w++) begin
      @(posedge clk); #1;
      dbus_ack = (w == v.ack_at);
      #1;
      if (!stall_req) done = 1;
      else begin
        nstall++;
        if (w == 1) begin
          chk({tag, ".req"}, dbus_req, 1'b1);
          chk({tag, ".dbus_we"}, dbus_we, st);
          chk({tag, ".sel"}, dbus_sel, v.exp_sel);
          chk({tag, ".daddr"}, dbus_addr, v.addr & 32'hFFFF_FFFC);
          if (st) chk({tag, ".dwdata"}, dbus_wdata, v.exp_dwd);
        end
      end
    end
    chk({tag, ".stall_cycles"}, nstall, v.exp_stall);
    chk({tag, ".done_req"}, dbus_req, 1'b0);
    chk({tag, ".bus_err"}, bus_err, v.exp_err);
    chk({tag, ".wb_we"}, wb_we, v.exp_wbwe);
    chk({tag, ".wb_waddr"}, wb_waddr, v.waddr);
    if (!v.exp_err) chk({tag, ".wb_wdata"}, wb_wdata, v.exp_wbd);
    dbus_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t tbl[15];
  vec_t rv;
  logic [31:0] ra;

  initial begin
    tbl[0]  = '{4'd0,  32'h0,   32'h0,        32'h0,        5'd3,  1'b1, 32'h1234, 0, 1'b0, 4'h0,    32'h0,        0, 1'b1, 32'h1234,     1'b0};
    tbl[1]  = '{4'd1,  32'h103, 32'h0,        32'h80FF_FF00, 5'd4, 1'b1, 32'h103,  1, 1'b0, 4'b1000, 32'h0,        2, 1'b1, 32'hFFFF_FF80, 1'b0};
    tbl[2]  = '{4'd7,  32'h202, 32'hDEAD_BEEF, 32'h0,       5'd0,  1'b0, 32'h202,  3, 1'b0, 4'b1100, 32'hBEEF_BEEF, 4, 1'b0, 32'h202,     1'b0};
    tbl[3]  = '{4'd5,  32'h101, 32'h0,        32'h0,        5'd5,  1'b1, 32'h101,  1, 1'b1, 4'h0,    32'h0,        0, 1'b0, 32'h101,      1'b0};
    tbl[4]  = '{4'd5,  32'h100, 32'h0,        32'hAAAA_5555, 5'd6, 1'b1, 32'h100, 99, 1'b0, 4'hF,    32'h0,        5, 1'b0, 32'h100,      1'b1};
    tbl[5]  = '{4'd5,  32'h100, 32'h0,        32'h1234_5678, 5'd6, 1'b1, 32'h100,  4, 1'b0, 4'hF,    32'h0,        5, 1'b1, 32'h1234_5678, 1'b0};
    tbl[6]  = '{4'd2,  32'h302, 32'h0,        32'h00AB_0000, 5'd7, 1'b1, 32'h302,  2, 1'b0, 4'b0100, 32'h0,        3, 1'b1, 32'h0000_00AB, 1'b0};
    tbl[7]  = '{4'd3,  32'h402, 32'h0,        32'h8001_0000, 5'd8, 1'b1, 32'h402,  1, 1'b0, 4'b1100, 32'h0,        2, 1'b1, 32'hFFFF_8001, 1'b0};
    tbl[8]  = '{4'd4,  32'h400, 32'h0,        32'h1234_F00D, 5'd9, 1'b1, 32'h400,  2, 1'b0, 4'b0011, 32'h0,        3, 1'b1, 32'h0000_F00D, 1'b0};
    tbl[9]  = '{4'd6,  32'h501, 32'h0000_00A5, 32'h0,       5'd0,  1'b0, 32'h501,  1, 1'b0, 4'b0010, 32'hA5A5_A5A5, 2, 1'b0, 32'h501,     1'b0};
    tbl[10] = '{4'd8,  32'h604, 32'hCAFE_F00D, 32'h0,       5'd1,  1'b1, 32'h604,  2, 1'b0, 4'hF,    32'hCAFE_F00D, 3, 1'b1, 32'h604,     1'b0};
    tbl[11] = '{4'd7,  32'h203, 32'h1,        32'h0,        5'd2,  1'b1, 32'h203,  1, 1'b1, 4'h0,    32'h0,        0, 1'b0, 32'h203,      1'b0};
    tbl[12] = '{4'd12, 32'h77,  32'h0,        32'h0,        5'd10, 1'b1, 32'h5A5A, 1, 1'b0, 4'h0,    32'h0,        0, 1'b1, 32'h5A5A,     1'b0};
    tbl[13] = '{4'd1,  32'h100, 32'h0,        32'h0000_00FF, 5'd11, 1'b1, 32'h100, 5, 1'b0, 4'b0001, 32'h0,        5, 1'b0, 32'h100,      1'b1};
    tbl[14] = '{4'd3,  32'h101, 32'h0,        32'h0,        5'd12, 1'b1, 32'h101,  1, 1'b1, 4'h0,    32'h0,        0, 1'b0, 32'h101,      1'b0};

    // Reset: outputs forced low even with a misaligned op on the inputs.
    rst = 1'b1; dbus_ack = 1'b0; dbus_rdata = 32'hFFFF_FFFF;
    mem_op = 4'd5; mem_addr = 32'h101; mem_sdata = 32'h1; mem_waddr = 5'd9;
    mem_we = 1'b1; mem_wdata = 32'hABCD;
    @(posedge clk); #1;
    chk("rst.misalign", misalign, 1'b0);
    chk("rst.wb_we", wb_we, 1'b0);
    chk("rst.wb_waddr", wb_waddr, 5'd0);
    chk("rst.wb_wdata", wb_wdata, 32'h0);
    chk("rst.stall", stall_req, 1'b0);
    chk("rst.dbus_addr", dbus_addr, 32'h0);
    chk("rst.dbus_sel", dbus_sel, 4'h0);
    @(posedge clk); #1;
    rst = 1'b0; mem_op = 4'd0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      rv = model(4'($urandom_range(0, 15)), ra, $urandom, $urandom,
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom,
                 $urandom_range(1, T + 2));
      run_txn(rv, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of WAIT, then a stray ack.
    mem_op = 4'd5; mem_addr = 32'h100; mem_we = 1'b1; mem_wdata = 32'h100;
    dbus_ack = 1'b0;
    @(posedge clk); #1;
    chk("midrst.wait_req", dbus_req, 1'b1);
    rst = 1'b1; #1;
    chk("midrst.req", dbus_req, 1'b0);
    chk("midrst.stall", stall_req, 1'b0);
    chk("midrst.dbus_wdata", dbus_wdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; mem_op = 4'd0; mem_waddr = 5'd12; mem_wdata = 32'h9999;
    dbus_ack = 1'b1; dbus_rdata = 32'h5555_5555; #1;
    chk("midrst.stray_stall", stall_req, 1'b0);
    chk("midrst.stray_req", dbus_req, 1'b0);
    chk("midrst.stray_wdata", wb_wdata, 32'h9999);
    chk("midrst.stray_err", bus_err, 1'b0);
    @(posedge clk); #1;
    dbus_ack = 1'b0; #1;
    chk("midrst.after_req", dbus_req, 1'b0);
    chk("midrst.after_wdata", wb_wdata, 32'h9999);
    chk("midrst.after_we", wb_we, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
